// File: rtl/fp32_mul_unit_pkg.sv
// Shared FPU definitions: FP32 field layout, special encodings, the
// multiplier sequencer states and the operand classification record.
package fp32_mul_unit_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MUL    = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Raw operand fields plus class flags; mant carries the hidden bit
    // only for normal numbers (exp field non-zero).
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W:0]   mant;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
        logic              is_sub;
    } fp_class_t;

endpackage

// File: rtl/fp32_mul_unit_if.sv
// FPU start/done handshake bundle. The initiator (master) drives start and
// operands; the unit (slave) returns result with done/busy status.
interface fp32_mul_unit_if;
    logic        start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        done;
    logic        busy;

    modport master (output start, output operand_a, output operand_b,
                    input  result, input  done, input  busy);
    modport slave  (input  start, input  operand_a, input  operand_b,
                    output result, output done, output busy);
endinterface

// File: rtl/fp32_mul_unit_classify.sv
// fp32_classify: combinational split of an FP32 word into sign, exponent
// and 24-bit mantissa, with zero/inf/NaN/subnormal flags.
module fp32_classify
    import fp32_mul_unit_pkg::*;
(
    input  logic [31:0] op,
    output fp_class_t   cls
);
    // Field extraction and class decode
    always_comb begin
        cls.sign    = op[31];
        cls.exp     = op[30:23];
        cls.mant    = {(op[30:23] != 8'd0), op[22:0]};
        cls.is_zero = (op[30:23] == 8'd0)   && (op[22:0] == 23'd0);
        cls.is_sub  = (op[30:23] == 8'd0)   && (op[22:0] != 23'd0);
        cls.is_inf  = (op[30:23] == 8'hFF)  && (op[22:0] == 23'd0);
        cls.is_nan  = (op[30:23] == 8'hFF)  && (op[22:0] != 23'd0);
    end
endmodule

// File: rtl/fp32_mul_unit.sv
// fp32_mul_unit: multi-cycle FP32 multiplier on the FPU start/done
// handshake. UNPACK -> MUL (24/BITS_PER_CYCLE cycles of shift-add) ->
// NORM -> ROUND (RNE + special cases) -> DONE, fixed latency.
// Build option FP32_MUL_SUBNORM_EN: gradual underflow and subnormal inputs;
// without it subnormal inputs and results flush to signed zero.
module fp32_mul_unit
    import fp32_mul_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4   // must divide 24
) (
    input  logic           clk,
    input  logic           rst,
    fp32_mul_unit_if.slave bus
);
    localparam int MUL_CYCLES = 24 / BITS_PER_CYCLE;
    localparam int CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d;
    logic [47:0]        prod_q, prod_d;
    logic [47:0]        mcand_q, mcand_d;
    logic [23:0]        mplier_q, mplier_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
    logic               sticky_q, sticky_d;
    logic [31:0]        result_q, result_d;
    logic               done_q, done_d, busy_q, busy_d;

    fp_class_t          ca, cb;
    logic [7:0]         ea_eff, eb_eff;
    logic               za, zb;

    fp32_classify u_cls_a (.op(opa_q), .cls(ca));
    fp32_classify u_cls_b (.op(opb_q), .cls(cb));

    // Round-to-nearest-even increment of a 24-bit mantissa (bit 24 = carry out)
    function automatic logic [24:0] rne(input logic [23:0] m, input logic g,
                                        input logic s);
        return {1'b0, m} + {24'd0, g & (s | m[0])};
    endfunction

    // Pack a finite, non-special product; p has its leading one at bit 46
    function automatic logic [31:0] round_pack(input logic s,
                                               input logic signed [9:0] e,
                                               input logic [46:0] p,
                                               input logic st);
        logic [24:0]       r;
        logic signed [9:0] e_r;
        logic [22:0]       frac;
`ifdef FP32_MUL_SUBNORM_EN
        logic [9:0]        sh;
        logic [46:0]       mask;
        logic [46:0]       p_sh;
        logic              st_sh;
`endif
        if (e >= 10'sd1) begin
            r    = rne(p[46:23], p[22], (|p[21:0]) | st);
            e_r  = e + (r[24] ? 10'sd1 : 10'sd0);
            frac = r[24] ? r[23:1] : r[22:0];
            if (e_r >= 10'sd255)
                return {s, POS_INF[30:0]};
            return {s, e_r[7:0], frac};
        end
`ifdef FP32_MUL_SUBNORM_EN
        // Denormalise: shift right by 1-e, folding lost bits into sticky.
        sh = 10'sd1 - e;
        if (sh >= 10'd25)
            return {s, 31'b0};
        mask  = (47'd1 << sh[4:0]) - 47'd1;
        st_sh = st | (|(p & mask));
        p_sh  = p >> sh[4:0];
        r     = rne(p_sh[46:23], p_sh[22], (|p_sh[21:0]) | st_sh);
        // A carry into bit 23 lands exactly on the smallest normal.
        return {s, 7'b0, r[23], r[22:0]};
`else
        return {s, 31'b0};
`endif
    endfunction

`ifdef FP32_MUL_SUBNORM_EN
    logic [5:0] norm_lz;
    logic [9:0] norm_room, norm_sh;

    // Leading zeros below bit 46 of a product from subnormal inputs
    function automatic logic [5:0] lead_zeros(input logic [46:0] p);
        logic [5:0] n;
        logic       found;
        n     = 6'd47;
        found = 1'b0;
        for (int i = 46; i >= 0; i--) begin
            if (!found && p[i]) begin
                n     = 6'(46 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Left-normalise amount, limited so the exponent does not drop below 1
    always_comb begin
        norm_lz   = lead_zeros(prod_q[46:0]);
        norm_room = exp_q - 10'sd1;
        norm_sh   = ({4'b0, norm_lz} > norm_room) ? norm_room : {4'b0, norm_lz};
    end

    // Subnormal operands take exponent 1 with no hidden bit
    always_comb begin
        ea_eff = ca.is_sub ? 8'd1 : ca.exp;
        eb_eff = cb.is_sub ? 8'd1 : cb.exp;
        za     = ca.is_zero;
        zb     = cb.is_zero;
    end
`else
    // Flush-to-zero: subnormal operands count as zero
    always_comb begin
        ea_eff = ca.exp;
        eb_eff = cb.exp;
        za     = ca.is_zero | ca.is_sub;
        zb     = cb.is_zero | cb.is_sub;
    end
`endif

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        sticky_d = sticky_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    opa_d   = bus.operand_a;
                    opb_d   = bus.operand_b;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d   = ca.sign ^ cb.sign;
                nan_d    = ca.is_nan | cb.is_nan | (ca.is_inf & zb) | (cb.is_inf & za);
                inf_d    = ca.is_inf | cb.is_inf;
                zero_d   = za | zb;
                exp_d    = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - 10'sd127;
                mcand_d  = {24'd0, ca.mant};
                mplier_d = cb.mant;
                prod_d   = 48'd0;
                sticky_d = 1'b0;
                cnt_d    = '0;
                state_d  = MUL;
            end
            MUL: begin
                // Retire the low multiplier digit, LSB first
                prod_d   = prod_q + mcand_q * 48'(mplier_q[BITS_PER_CYCLE-1:0]);
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                if (cnt_q == CNT_LAST)
                    state_d = NORM;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            NORM: begin
                if (prod_q[47]) begin
                    prod_d   = {1'b0, prod_q[47:1]};
                    sticky_d = prod_q[0];
                    exp_d    = exp_q + 10'sd1;
                end
`ifdef FP32_MUL_SUBNORM_EN
                else if (!prod_q[46] && (exp_q > 10'sd1)) begin
                    prod_d = prod_q << norm_sh;
                    exp_d  = exp_q - $signed(norm_sh);
                end
`endif
                state_d = ROUND;
            end
            ROUND: begin
                if (nan_q)
                    result_d = QNAN;
                else if (inf_q)
                    result_d = {sign_q, POS_INF[30:0]};
                else if (zero_q)
                    result_d = {sign_q, 31'b0};
                else
                    result_d = round_pack(sign_q, exp_q, prod_q[46:0], sticky_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_fp32_mul_unit.sv
// Bench for fp32_mul_unit: directed vectors with hand-computed products.
// Stimulus pushes the expected result and done cycle; a monitor pops and
// compares on every rising edge of done.
module tb_fp32_mul_unit;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    fp32_mul_unit_if bus ();

    fp32_mul_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic done_prev = 1'b0;

`ifdef FP32_MUL_SUBNORM_EN
    localparam logic [31:0] EXP_HALF_MIN = 32'h00400000;
    localparam logic [31:0] EXP_SUB_UP   = 32'h00800000;
`else
    localparam logic [31:0] EXP_HALF_MIN = 32'h00000000;
    localparam logic [31:0] EXP_SUB_UP   = 32'h00000000;
`endif

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare on each rising edge of done
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got result %h with no pending op at cycle %0d",
                             bus.result, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_result"}, bus.result, mon_e.res);
                    check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
                end
            end
            done_prev = bus.done;
        end
    end

    // Drive start at the current negedge; returns one negedge after acceptance
    task automatic issue_now(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expv, input string name,
                             input bit track);
        bus.start     = 1'b1;
        bus.operand_a = a;
        bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        if (track) sb.push_back('{expv, cyc + 9, name});
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input string name,
                         input bit track);
        @(negedge clk);
        issue_now(a, b, expv, name, track);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            if (bus.done) return;
            @(negedge clk);
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s_timeout: done still %b, expected 1 within 40 cycles", name, bus.done);
    endtask

    task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expv, input string name);
        issue(a, b, expv, name, 1'b1);
        wait_done(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy_ok;
        logic quiet;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_result", bus.result, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;

        // 1.5 * 2 with busy window observed
        issue(32'h3FC00000, 32'h40000000, 32'h40400000, "mul_1p5x2", 1'b1);
        busy_ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (!(bus.busy === 1'b1 && bus.done === 1'b0)) busy_ok = 1'b0;
            @(negedge clk);
        end
        check("busy_window", {31'd0, busy_ok}, 32'd1);
        check("busy_at_done", {30'd0, bus.busy, bus.done}, 32'd1);

        run_vec(32'hBF800000, 32'h40000000, 32'hC0000000, "neg_one_x2");
        run_vec(32'h3F800001, 32'h3F800001, 32'h3F800002, "sticky_down");
        run_vec(32'h3F800001, 32'h3FC00000, 32'h3FC00002, "tie_to_even_up");
        run_vec(32'h3F800003, 32'h3FC00000, 32'h3FC00004, "tie_to_even_down");
        run_vec(32'h40400000, 32'h40400000, 32'h41100000, "three_sq");
        run_vec(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "norm_shift");
        run_vec(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
        run_vec(32'hFFC00000, 32'h3F800000, 32'h7FC00000, "nan_in");
        run_vec(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf");
        run_vec(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
        run_vec(32'h80000000, 32'h3F800000, 32'h80000000, "neg_zero");
        run_vec(32'h00800000, 32'h3F000000, EXP_HALF_MIN, "underflow_half");
        run_vec(32'h80800000, 32'h00800000, 32'h80000000, "deep_underflow");
        run_vec(32'h00000001, 32'h4B000000, EXP_SUB_UP, "sub_input");

        // start held through the whole op; operand changes mid-op ignored
        @(negedge clk);
        bus.start     = 1'b1;
        bus.operand_a = 32'h3FC00000;
        bus.operand_b = 32'h40000000;
        @(negedge clk);
        sb.push_back('{32'h40400000, cyc + 9, "held_start"});
        bus.operand_a = 32'h7F800000;
        bus.operand_b = 32'h00000000;
        wait_done("held_start");
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("held_done_level", {30'd0, bus.busy, bus.done}, 32'd1);

        // new start on the first cycle done is seen
        run_vec(32'h40400000, 32'h3F800000, 32'h40400000, "before_on_done");
        issue_now(32'hBF800000, 32'h40000000, 32'hC0000000, "start_on_done", 1'b1);
        check("on_done_drop", {30'd0, bus.busy, bus.done}, 32'd2);
        wait_done("start_on_done");

        // reset four cycles into MUL aborts the op
        issue(32'h3FC00000, 32'h40000000, 32'h0, "aborted", 1'b0);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_result", bus.result, 32'd0);
        check("abort_done_busy", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus.done !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("abort_no_done", {31'd0, quiet}, 32'd1);
        run_vec(32'h3FC00000, 32'h40000000, 32'h40400000, "after_abort");

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
